// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle for the shift-add multiplier.
interface shift_add_multiplier_if #(
    parameter int unsigned N = 8
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N radix-2 shift-add multiplier.
// One N-bit ripple add per step, N steps per product; result held until the next done.
module shift_add_multiplier #(
    parameter int unsigned N = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  mcand;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          busy_r;
    logic          done_r;
    logic [PW-1:0] product_r;
    logic [PW-1:0] shifted;
    logic          accept;

    // Ripple-carry partial-sum adder, carry-in 0; carry-out must survive into hi
    always_comb begin
        logic c;
        addend = lo[0] ? mcand : '0;
        c      = 1'b0;
        sum    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = hi[i] ^ addend[i] ^ c;
            c      = (hi[i] & addend[i]) | (c & (hi[i] ^ addend[i]));
        end
        carry = c;
    end

    assign shifted = {carry, sum, lo[N-1:1]};
    assign accept  = bus.start && (state != BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                state  <= BUSY;
                busy_r <= 1'b1;
                mcand  <= bus.a;
                lo     <= bus.b;
                hi     <= '0;
                cnt    <= '0;
            end else begin
                case (state)
                    BUSY: begin
                        {hi, lo} <= shifted;
                        if (cnt == CW'(N - 1)) begin
                            // Final step: publish product; cnt parks at N-1 instead of wrapping
                            state     <= DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            product_r <= shifted;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    IDLE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule
